// File: rtl/sum_uart_tx.sv
// sum_uart_tx: buffers adder sum bytes in a small FIFO and sends each one
// as an 8N1 UART frame on a single tx pin.
module sum_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sum_in,
    input  logic       sum_stb,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [7:0]        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              fifo_full_q, fifo_full_d;
    logic              overflow_q, overflow_d;

    logic              fifo_empty_c;
    logic              baud_end_c;
    logic              push_c;
    logic              pop_c;

    assign fifo_empty_c = (count_q == '0);
    assign baud_end_c   = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    // Full is taken from the registered flag, so a pop in the same cycle cannot admit a push.
    assign push_c       = sum_stb & ~fifo_full_q;
    assign pop_c        = ~fifo_empty_c &
                          ((state_q == IDLE) | ((state_q == STOP) & baud_end_c));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: frame sequencing, back-to-back when the FIFO still has data
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!fifo_empty_c) state_d = START;
            START: if (baud_end_c) state_d = DATA;
            DATA:  if (baud_end_c && (bit_idx_q == 3'd7)) state_d = STOP;
            STOP:  if (baud_end_c) state_d = fifo_empty_c ? IDLE : START;
            default: state_d = IDLE;
        endcase
    end

    // Outputs and datapath next values: FIFO, baud/bit counters, shifter, flags
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        baud_d      = baud_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        tx_d        = 1'b1;

        if (push_c) begin
            mem_d[wr_ptr_q] = sum_in;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            shift_d  = mem_q[rd_ptr_q];
        end else if ((state_q == DATA) && baud_end_c) begin
            shift_d = {1'b0, shift_q[7:1]};
        end

        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

        if ((state_q == IDLE) || baud_end_c) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + BAUD_W'(1);
        end

        if ((state_q == START) && baud_end_c) begin
            bit_idx_d = 3'd0;
        end else if ((state_q == DATA) && baud_end_c) begin
            bit_idx_d = bit_idx_q + 3'd1;
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase

        busy_d      = (state_d != IDLE) || (count_d != '0);
        fifo_full_d = (count_d == CNT_W'(FIFO_DEPTH));
        overflow_d  = overflow_q | (sum_stb & fifo_full_q);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            baud_q      <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            fifo_full_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            baud_q      <= baud_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            fifo_full_q <= fifo_full_d;
            overflow_q  <= overflow_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign fifo_full = fifo_full_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_sum_uart_tx.sv
// Testbench for sum_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_sum_uart_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] sum_in;
    logic       sum_stb;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic       overflow;

    int n_tests;
    int n_fail;
    int cyc;

    logic [7:0] rx_q[$];
    int         rx_t[$];
    logic [7:0] exp_q[$];

    sum_uart_tx #(
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sum_in   (sum_in),
        .sum_stb  (sum_stb),
        .tx       (tx),
        .busy     (busy),
        .fifo_full(fifo_full),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rx_at(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 8'hxx;
    endfunction

    function automatic int gap_at(input int i);
        if (i + 1 < rx_t.size()) return rx_t[i+1] - rx_t[i];
        return -1;
    endfunction

    task automatic tickn(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives a strobe so that it is captured by the next rising edge.
    task automatic strobe(input logic [7:0] v);
        sum_in  = v;
        sum_stb = 1'b1;
        @(posedge clk);
        #1;
        sum_stb = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tickn(3);
        rst_n = 1'b1;
        tickn(2);
        rx_q.delete();
        rx_t.delete();
    endtask

    // UART monitor: start detected at edge S, bits sampled mid-window.
    initial begin : monitor
        logic [7:0] b;
        int         t0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n === 1'b1 && tx === 1'b0) begin
                t0 = cyc;
                b  = '0;
                repeat (2) @(posedge clk);
                #1;
                check("mon_start", 32'(tx), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(posedge clk);
                    #1;
                    b[i] = tx;
                end
                repeat (4) @(posedge clk);
                #1;
                check("mon_stop", 32'(tx), 32'd1);
                rx_q.push_back(b);
                rx_t.push_back(t0);
            end
        end
    end

    initial begin : stim
        logic exp_bits [8];
        int   bad;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        sum_in  = '0;
        sum_stb = 1'b0;
        exp_bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset values while held in reset
        tickn(3);
        check("rst_tx",   32'(tx),        32'd1);
        check("rst_busy", 32'(busy),      32'd0);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_ovf",  32'(overflow),  32'd0);
        rst_n = 1'b1;
        tickn(2);

        // Single byte 0xA5
        strobe(8'hA5);                       // edge N
        check("t2_tx_n", 32'(tx), 32'd1);
        tickn(1);                            // N+1
        check("t2_tx_start", 32'(tx), 32'd0);
        check("t2_busy", 32'(busy), 32'd1);
        tickn(2);                            // N+3
        check("t2_tx_start_end", 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tickn(4);                        // N+7+4i
            check($sformatf("t2_bit%0d", i), 32'(tx), 32'(exp_bits[i]));
        end
        tickn(4);                            // N+39
        check("t2_stop", 32'(tx), 32'd1);
        tickn(1);                            // N+40
        check("t2_busy_hold", 32'(busy), 32'd1);
        tickn(1);                            // N+41
        check("t2_busy_drop", 32'(busy), 32'd0);
        check("t2_nbytes", 32'(rx_q.size()), 32'd1);
        check("t2_byte", 32'(rx_at(0)), 32'hA5);

        // Back-to-back 0x01, 0xFE
        do_reset();
        strobe(8'h01);
        strobe(8'hFE);
        tickn(90);
        check("t3_nbytes", 32'(rx_q.size()), 32'd2);
        check("t3_byte0", 32'(rx_at(0)), 32'h01);
        check("t3_byte1", 32'(rx_at(1)), 32'hFE);
        check("t3_gap", 32'(gap_at(0)), 32'd40);
        check("t3_busy", 32'(busy), 32'd0);

        // Full and overflow: 0x10..0x15 on consecutive edges
        do_reset();
        for (int i = 0; i < 6; i++) strobe(8'h10 + 8'(i));
        check("t4_full", 32'(fifo_full), 32'd1);
        check("t4_ovf", 32'(overflow), 32'd1);
        tickn(220);
        check("t4_ovf_sticky", 32'(overflow), 32'd1);
        check("t4_full_clr", 32'(fifo_full), 32'd0);
        check("t4_nbytes", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_byte%0d", i), 32'(rx_at(i)), 32'h10 + 32'(i));
        end

        // Push and pop on the same edge at STOP end
        do_reset();
        strobe(8'h3C);                       // edge N
        strobe(8'hC3);                       // edge N+1, stays queued
        tickn(39);                           // N+40
        check("t5_cnt_before", 32'(dut.count_q), 32'd1);
        strobe(8'h5A);                       // edge N+41: push + pop
        check("t5_cnt_after", 32'(dut.count_q), 32'd1);
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_full", 32'(fifo_full), 32'd0);
        tickn(100);
        check("t5_nbytes", 32'(rx_q.size()), 32'd3);
        check("t5_byte0", 32'(rx_at(0)), 32'h3C);
        check("t5_byte1", 32'(rx_at(1)), 32'hC3);
        check("t5_byte2", 32'(rx_at(2)), 32'h5A);
        check("t5_gap0", 32'(gap_at(0)), 32'd40);
        check("t5_gap1", 32'(gap_at(1)), 32'd40);

        // Scoreboard: random bytes with spacing >= 40 cycles
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 200; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            exp_q.push_back(v);
            strobe(v);
            tickn(39 + int'($urandom_range(0, 20)));
        end
        tickn(60);
        check("t6_nbytes", 32'(rx_q.size()), 32'd200);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (rx_at(i) !== exp_q[i]) bad++;
        end
        check("t6_bytes_bad", 32'(bad), 32'd0);
        check("t6_ovf", 32'(overflow), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);

        // Reset in the middle of a DATA bit
        strobe(8'h00);                       // edge N
        tickn(10);                           // N+10, bit 1 of 0x00
        check("t1_tx_data", 32'(tx), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t1_tx_async", 32'(tx), 32'd1);
        check("t1_busy_async", 32'(busy), 32'd0);
        tickn(1);
        rst_n = 1'b1;
        tickn(1);
        check("t1_state_idle", 32'(dut.state_q), 32'd0);
        bad = 0;
        for (int i = 0; i < 45; i++) begin
            tickn(1);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("t1_stays_idle", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
